// File: rtl/dispense_request_controller.sv
// rtl/dispense_request_controller.sv - input conditioning and dispense request FSM
//
// Conditions the user button, cup sensor and tank-low flag, then issues
// single-cycle start/stop requests to the downstream water dispenser and
// enforces a cooldown between dispenses.
//
// Ports:
//   clk             - system clock, rising edge
//   reset           - synchronous, active-high
//   btn_raw         - asynchronous push-button, high = pressed
//   cup_raw         - asynchronous cup sensor, high = cup present
//   tank_low        - asynchronous tank-low flag, high = insufficient water
//   dispense_active - dispenser feedback, high while water flows
//   start_dispense  - registered one-cycle start request
//   stop_dispense   - registered one-cycle stop request
//   ctrl_state      - FSM state (0 IDLE, 1 READY, 2 DISPENSE, 3 COOLDOWN)
//   dispense_count  - saturating count of start pulses (DISPENSE_COUNT_EN only)
//
// Optional feature macro: DISPENSE_COUNT_EN
module dispense_request_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       cup_raw,
  input  logic       tank_low,
  input  logic       dispense_active,
  output logic       start_dispense,
  output logic       stop_dispense,
`ifdef DISPENSE_COUNT_EN
  output logic [7:0] dispense_count,
`endif
  output logic [1:0] ctrl_state
);

  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] CD_LAST  = 4'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_READY    = 2'd1,
    S_DISPENSE = 2'd2,
    S_COOLDOWN = 2'd3
  } state_e;

  // Two-flop synchronizers; bit [1] is the synchronized value.
  logic [1:0] btn_sync_q, cup_sync_q, tank_sync_q;
  logic       btn_s, cup_s, tank_s;

  logic       btn_db_q, btn_db_prev_q, cup_db_q;
  logic [3:0] btn_cnt_q, cup_cnt_q;
  logic       btn_press;

  state_e     state_q, state_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       seen_active_q, seen_active_d;
  logic [3:0] cool_cnt_q, cool_cnt_d;

  logic       ready_abort, manual_stop, auto_stop;

  assign btn_s  = btn_sync_q[1];
  assign cup_s  = cup_sync_q[1];
  assign tank_s = tank_sync_q[1];

  // Returns {debounced, counter} for the next edge. The counter only runs
  // while the synchronized input disagrees with the debounced value, so any
  // agreement restarts the qualification window.
  function automatic logic [4:0] db_next(input logic s, input logic db,
                                         input logic [3:0] cnt);
    if (s == db)
      return {db, 4'd0};
    else if (cnt + 4'd1 == DB_LIMIT)
      return {~db, 4'd0};
    else
      return {db, cnt + 4'd1};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync_q    <= 2'b00;
      cup_sync_q    <= 2'b00;
      tank_sync_q   <= 2'b00;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      cup_db_q      <= 1'b0;
      btn_cnt_q     <= 4'd0;
      cup_cnt_q     <= 4'd0;
    end else begin
      btn_sync_q    <= {btn_sync_q[0], btn_raw};
      cup_sync_q    <= {cup_sync_q[0], cup_raw};
      tank_sync_q   <= {tank_sync_q[0], tank_low};
      {btn_db_q, btn_cnt_q} <= db_next(btn_s, btn_db_q, btn_cnt_q);
      {cup_db_q, cup_cnt_q} <= db_next(cup_s, cup_db_q, cup_cnt_q);
      btn_db_prev_q <= btn_db_q;
    end
  end

  assign btn_press   = btn_db_q & ~btn_db_prev_q;
  assign ready_abort = ~cup_db_q | tank_s;
  assign manual_stop = ~cup_db_q | btn_press | tank_s;
  assign auto_stop   = seen_active_q & ~dispense_active;

  // State register (FSM state plus the registered outputs it drives).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      stop_q        <= 1'b0;
      seen_active_q <= 1'b0;
      cool_cnt_q    <= 4'd0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      stop_q        <= stop_d;
      seen_active_q <= seen_active_d;
      cool_cnt_q    <= cool_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (cup_db_q && !tank_s) state_d = S_READY;
      S_READY: begin
        if (ready_abort)    state_d = S_IDLE;
        else if (btn_press) state_d = S_DISPENSE;
      end
      S_DISPENSE: if (manual_stop || auto_stop) state_d = S_COOLDOWN;
      S_COOLDOWN: if (cool_cnt_q == CD_LAST) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic. The cooldown counter is held at zero while dispensing so
  // it starts from zero on COOLDOWN entry whichever stop rule fired.
  always_comb begin
    start_d       = 1'b0;
    stop_d        = 1'b0;
    seen_active_d = seen_active_q;
    cool_cnt_d    = 4'd0;
    case (state_q)
      S_READY: begin
        start_d = ~ready_abort & btn_press;
        if (start_d) seen_active_d = 1'b0;
      end
      S_DISPENSE: begin
        stop_d = manual_stop;
        if (dispense_active) seen_active_d = 1'b1;
      end
      S_COOLDOWN: cool_cnt_d = cool_cnt_q + 4'd1;
      default: ;
    endcase
  end

  assign start_dispense = start_q;
  assign stop_dispense  = stop_q;
  assign ctrl_state     = state_q;

`ifdef DISPENSE_COUNT_EN
  logic [7:0] count_q;

  // Counts alongside the registered pulse, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset)
      count_q <= 8'd0;
    else if (start_d && count_q != 8'hFF)
      count_q <= count_q + 8'd1;
  end

  assign dispense_count = count_q;
`endif

endmodule

// File: tb/tb_dispense_request_controller.sv
// tb/tb_dispense_request_controller.sv - self-checking bench for dispense_request_controller
module tb_dispense_request_controller;

  localparam int DB = 4;
  localparam int CD = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_raw = 1'b0;
  logic       cup_raw = 1'b0;
  logic       tank_low = 1'b0;
  logic       dispense_active = 1'b0;
  logic       start_dispense;
  logic       stop_dispense;
  logic [1:0] ctrl_state;
`ifdef DISPENSE_COUNT_EN
  logic [7:0] dispense_count;
`endif

  always #5 clk = ~clk;

  dispense_request_controller #(
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_CYCLES(CD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_raw        (btn_raw),
    .cup_raw        (cup_raw),
    .tank_low       (tank_low),
    .dispense_active(dispense_active),
    .start_dispense (start_dispense),
    .stop_dispense  (stop_dispense),
`ifdef DISPENSE_COUNT_EN
    .dispense_count (dispense_count),
`endif
    .ctrl_state     (ctrl_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: raw sample history, debounce as "last DB synchronized
  // samples all disagree", and the request FSM as plain rules.
  bit rb[$], rc[$], rt[$];
  bit wb[$], wc[$];
  bit m_db_b, m_db_b_prev, m_db_c;
  int m_state, m_cd, m_count;
  bit m_seen, m_start, m_stop;

  task automatic model_reset();
    rb = {1'b0, 1'b0}; rc = {1'b0, 1'b0}; rt = {1'b0, 1'b0};
    wb.delete(); wc.delete();
    for (int i = 0; i < DB; i++) begin wb.push_back(1'b0); wc.push_back(1'b0); end
    m_db_b = 0; m_db_b_prev = 0; m_db_c = 0;
    m_state = 0; m_cd = 0; m_count = 0;
    m_seen = 0; m_start = 0; m_stop = 0;
  endtask

  task automatic model_edge(input bit rst, input bit b, input bit c, input bit t, input bit a);
    bit sb, sc, st, press, all_b, all_c;
    if (rst) begin
      model_reset();
      return;
    end
    sb = rb[0]; sc = rc[0]; st = rt[0];
    press = m_db_b && !m_db_b_prev;
    m_start = 0; m_stop = 0;
    case (m_state)
      0: if (m_db_c && !st) m_state = 1;
      1: begin
        if (!m_db_c || st) m_state = 0;
        else if (press) begin m_start = 1; m_state = 2; m_seen = 0; end
      end
      2: begin
        if (!m_db_c || press || st) begin m_stop = 1; m_state = 3; m_cd = 0; end
        else if (m_seen && !a) begin m_state = 3; m_cd = 0; end
        if (a) m_seen = 1;
      end
      default: begin
        if (m_cd == CD - 1) m_state = 0;
        else m_cd++;
      end
    endcase
    if (m_start && m_count < 255) m_count++;
    void'(rb.pop_front()); rb.push_back(b);
    void'(rc.pop_front()); rc.push_back(c);
    void'(rt.pop_front()); rt.push_back(t);
    void'(wb.pop_front()); wb.push_back(sb);
    void'(wc.pop_front()); wc.push_back(sc);
    all_b = 1; all_c = 1;
    foreach (wb[i]) if (wb[i] == m_db_b) all_b = 0;
    foreach (wc[i]) if (wc[i] == m_db_c) all_c = 0;
    m_db_b_prev = m_db_b;
    if (all_b) m_db_b = !m_db_b;
    if (all_c) m_db_c = !m_db_c;
  endtask

  int cnt_start, cnt_stop, cnt_cool;

  task automatic clear_counts();
    cnt_start = 0; cnt_stop = 0; cnt_cool = 0;
  endtask

  task automatic step(input bit rst, input bit b, input bit c, input bit t, input bit a);
    reset = rst; btn_raw = b; cup_raw = c; tank_low = t; dispense_active = a;
    @(posedge clk);
    model_edge(rst, b, c, t, a);
    #1;
    check_eq("ctrl_state", 32'(ctrl_state), 32'(m_state));
    check_eq("start_dispense", 32'(start_dispense), 32'(m_start));
    check_eq("stop_dispense", 32'(stop_dispense), 32'(m_stop));
    check_eq("pulse_exclusive", 32'(start_dispense & stop_dispense), 32'd0);
`ifdef DISPENSE_COUNT_EN
    check_eq("dispense_count", 32'(dispense_count), 32'(m_count));
`endif
    if (start_dispense) cnt_start++;
    if (stop_dispense) cnt_stop++;
    if (ctrl_state == 2'd3) cnt_cool++;
  endtask

  task automatic hold(input int n, input bit b, input bit c, input bit t, input bit a);
    for (int i = 0; i < n; i++) step(1'b0, b, c, t, a);
  endtask

  initial begin
    int lat;
    bit b, c, t, a, r;
    model_reset();
    clear_counts();

    // Reset state.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_eq("reset_state", 32'(ctrl_state), 32'd0);

    // Cup arrives -> READY; button held -> start 6 edges after first sample.
    hold(10, 0, 1, 0, 0);
    check_eq("ready_after_cup", 32'(ctrl_state), 32'd1);
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 1, 0, 0);
      if (start_dispense && lat < 0) lat = k;
    end
    check_eq("start_latency", 32'(lat), 32'd6);
    check_eq("dispense_state", 32'(ctrl_state), 32'd2);

    // Flowing, button released; then cup removed with a press during cooldown.
    hold(8, 0, 1, 0, 1);
    check_eq("still_dispensing", 32'(ctrl_state), 32'd2);
    clear_counts();
    hold(4, 0, 0, 0, 1);
    hold(16, 1, 0, 0, 1);
    check_eq("cup_stop_pulses", 32'(cnt_stop), 32'd1);
    check_eq("cooldown_len", 32'(cnt_cool), 32'(CD));
    check_eq("no_start_in_cooldown", 32'(cnt_start), 32'd0);
    check_eq("idle_after_cooldown", 32'(ctrl_state), 32'd0);

    // Auto-stop when flow ends: no stop pulse.
    hold(12, 0, 1, 0, 0);
    hold(8, 1, 1, 0, 0);
    check_eq("auto_dispense_state", 32'(ctrl_state), 32'd2);
    clear_counts();
    hold(10, 1, 1, 0, 1);
    hold(12, 1, 1, 0, 0);
    check_eq("auto_no_stop", 32'(cnt_stop), 32'd0);
    check_eq("auto_cooldown_len", 32'(cnt_cool), 32'(CD));

    // Short button glitch in READY.
    hold(10, 0, 1, 0, 0);
    clear_counts();
    hold(3, 1, 1, 0, 0);
    hold(10, 0, 1, 0, 0);
    check_eq("glitch_no_start", 32'(cnt_start), 32'd0);
    check_eq("glitch_ready", 32'(ctrl_state), 32'd1);

    // Tank low in READY -> IDLE, presses ignored.
    hold(6, 0, 1, 1, 0);
    check_eq("tank_idle", 32'(ctrl_state), 32'd0);
    clear_counts();
    hold(10, 1, 1, 1, 0);
    check_eq("tank_no_start", 32'(cnt_start), 32'd0);
    hold(10, 0, 1, 0, 0);

    // Reset while dispensing.
    hold(8, 1, 1, 0, 1);
    check_eq("pre_reset_dispense", 32'(ctrl_state), 32'd2);
    step(1, 1, 1, 0, 1);
    check_eq("mid_reset_state", 32'(ctrl_state), 32'd0);
    check_eq("mid_reset_stop", 32'(stop_dispense), 32'd0);
    hold(12, 0, 1, 0, 0);

    // Randomized traffic against the model.
    b = 0; c = 1; t = 0; a = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 6) == 0) b = !b;
      if ($urandom_range(0, 24) == 0) c = !c;
      if (t) begin
        if ($urandom_range(0, 3) == 0) t = 0;
      end else if ($urandom_range(0, 59) == 0) t = 1;
      if ($urandom_range(0, 7) == 0) a = !a;
      r = ($urandom_range(0, 399) == 0);
      step(r, b, c, t, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
